// File: rtl/mvu_pkg.sv
// Shared MVU constants, transposer FSM state type and the precision clamp helper.
package mvu_pkg;

   localparam int unsigned N       = 64;
   localparam int unsigned BDBANKA = 15;
   localparam int unsigned BDBANKW = 64;

   typedef enum logic [1:0] {
      TP_IDLE,
      TP_COLLECT,
      TP_EMIT
   } tp_state_e;

   // Zero or over-range precision falls back to the widest supported precision.
   function automatic logic [31:0] clamp_prec(input logic [31:0] prec,
                                              input int unsigned max_prec);
      if (prec == 32'd0 || prec > max_prec) begin
         return max_prec;
      end
      return prec;
   endfunction

endpackage

// File: rtl/mvu_tp_plane_mux.sv
// Selects one bit column across all buffered elements, forming a bit-plane word.
module mvu_tp_plane_mux #(
   parameter int unsigned NUM_WORDS     = 64,
   parameter int unsigned MAX_DATA_PREC = 16
) (
   input  logic [MAX_DATA_PREC-1:0]         rows [NUM_WORDS],
   input  logic [$clog2(MAX_DATA_PREC)-1:0] sel,
   output logic [NUM_WORDS-1:0]             word
);

   always_comb begin
      word = '0;
      for (int j = 0; j < NUM_WORDS; j++) begin
         word[j] = rows[j][sel];
      end
   end

endmodule

// File: rtl/mvu_bitplane_transposer.sv
// Collects NUM_WORDS scalar elements and writes them to the MVU data RAM as
// MSB-first bit-plane words, one plane per cycle.
module mvu_bitplane_transposer
   import mvu_pkg::*;
#(
   parameter int unsigned NUM_WORDS     = N,
   parameter int unsigned XLEN          = 32,
   parameter int unsigned MVU_ADDR_LEN  = BDBANKA,
   parameter int unsigned MVU_DATA_LEN  = BDBANKW,
   parameter int unsigned MAX_DATA_PREC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             prec,
   input  logic [31:0]             baddr,
   input  logic                    start,
   input  logic [XLEN-1:0]         iword,
   input  logic                    iword_valid,
   output logic                    iword_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    mvu_wr_en,
   output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
   output logic [MVU_DATA_LEN-1:0] mvu_wr_word
);

   localparam int unsigned CW = $clog2(NUM_WORDS) + 1;
   localparam int unsigned PW = $clog2(MAX_DATA_PREC) + 1;

   if (NUM_WORDS != MVU_DATA_LEN) begin : g_len_chk
      $error("NUM_WORDS must equal MVU_DATA_LEN");
   end
   if (MAX_DATA_PREC > XLEN) begin : g_prec_chk
      $error("MAX_DATA_PREC must not exceed XLEN");
   end

   tp_state_e                state_q, state_d;
   logic [CW-1:0]            word_cnt_q, word_cnt_d;
   logic [PW-1:0]            plane_q, plane_d;
   logic [PW-1:0]            idx_q, idx_d;
   logic [PW-1:0]            eff_prec_q, eff_prec_d;
   logic [MVU_ADDR_LEN-1:0]  baddr_q, baddr_d;
   logic [MAX_DATA_PREC-1:0] row_q [NUM_WORDS];
   logic                     row_we;
   logic [CW-2:0]            row_sel;
   logic [NUM_WORDS-1:0]     plane_word;
   logic                     unused_bits;

   assign unused_bits = ^{baddr[31:MVU_ADDR_LEN], iword[XLEN-1:MAX_DATA_PREC]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= TP_IDLE;
         word_cnt_q <= '0;
         plane_q    <= '0;
         idx_q      <= '0;
         eff_prec_q <= '0;
         baddr_q    <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         plane_q    <= plane_d;
         idx_q      <= idx_d;
         eff_prec_q <= eff_prec_d;
         baddr_q    <= baddr_d;
      end
   end

   // Element buffer carries no reset; stale rows are always overwritten before use.
   always_ff @(posedge clk) begin
      if (row_we) begin
         row_q[row_sel] <= iword[MAX_DATA_PREC-1:0];
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      plane_d    = plane_q;
      idx_d      = idx_q;
      eff_prec_d = eff_prec_q;
      baddr_d    = baddr_q;
      row_we     = 1'b0;
      row_sel    = '0;
      unique case (state_q)
         TP_IDLE: begin
            if (start) begin
               eff_prec_d = PW'(clamp_prec(prec, MAX_DATA_PREC));
               baddr_d    = baddr[MVU_ADDR_LEN-1:0];
               word_cnt_d = CW'(1);
               row_we     = 1'b1;
               state_d    = TP_COLLECT;
            end
         end
         TP_COLLECT: begin
            if (iword_valid) begin
               row_we     = 1'b1;
               row_sel    = word_cnt_q[CW-2:0];
               word_cnt_d = word_cnt_q + CW'(1);
               if (word_cnt_q == CW'(NUM_WORDS - 1)) begin
                  state_d    = TP_EMIT;
                  word_cnt_d = '0;
                  plane_d    = eff_prec_q - PW'(1);
                  idx_d      = '0;
               end
            end
         end
         TP_EMIT: begin
            plane_d = plane_q - PW'(1);
            idx_d   = idx_q + PW'(1);
            if (plane_q == '0) begin
               state_d = TP_IDLE;
               plane_d = '0;
               idx_d   = '0;
            end
         end
         default: state_d = TP_IDLE;
      endcase
   end

   mvu_tp_plane_mux #(
      .NUM_WORDS     (NUM_WORDS),
      .MAX_DATA_PREC (MAX_DATA_PREC)
   ) u_plane_mux (
      .rows (row_q),
      .sel  (plane_q[PW-2:0]),
      .word (plane_word)
   );

   // Outputs derive only from registered state, so reset clears them at once.
   always_comb begin
      mvu_wr_en   = 1'b0;
      mvu_wr_addr = '0;
      mvu_wr_word = '0;
      done        = 1'b0;
      busy        = (state_q != TP_IDLE);
      iword_ready = (state_q != TP_EMIT);
      if (state_q == TP_EMIT) begin
         mvu_wr_en   = 1'b1;
         mvu_wr_addr = baddr_q + MVU_ADDR_LEN'(idx_q);
         mvu_wr_word = plane_word;
         done        = (plane_q == '0);
      end
   end

endmodule

// File: tb/tb_mvu_bitplane_transposer.sv
// Scoreboard bench: expected plane writes are queued at stimulus time and
// popped as the transposer emits them.
module tb_mvu_bitplane_transposer;

   localparam int NW = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] prec;
   logic [31:0] baddr;
   logic        start;
   logic [31:0] iword;
   logic        iword_valid;
   logic        iword_ready;
   logic        busy;
   logic        done;
   logic        mvu_wr_en;
   logic [14:0] mvu_wr_addr;
   logic [63:0] mvu_wr_word;

   typedef struct {
      logic [14:0] addr;
      logic [63:0] word;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] elem [NW];
   bit          gap_at [NW];
   int          n_total = 0;
   int          n_bad   = 0;
   bit          prev_done = 0;
   bit          prev_wr   = 0;

   always #5 clk = ~clk;

   mvu_bitplane_transposer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prec        (prec),
      .baddr       (baddr),
      .start       (start),
      .iword       (iword),
      .iword_valid (iword_valid),
      .iword_ready (iword_ready),
      .busy        (busy),
      .done        (done),
      .mvu_wr_en   (mvu_wr_en),
      .mvu_wr_addr (mvu_wr_addr),
      .mvu_wr_word (mvu_wr_word)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write monitor, sampled just after the active edge.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (prev_done) check("busy_after_done", 64'(busy), 64'd0);
         if (prev_wr && !prev_done) check("write_gap", 64'(mvu_wr_en), 64'd1);
         if (mvu_wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(mvu_wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wr_addr", 64'(mvu_wr_addr), 64'(e.addr));
               check("wr_word", mvu_wr_word, e.word);
               check("wr_done", 64'(done), 64'(e.last));
               check("ready_in_emit", 64'(iword_ready), 64'd0);
            end
         end
         prev_done = done;
         prev_wr   = mvu_wr_en;
      end else begin
         prev_done = 0;
         prev_wr   = 0;
      end
   end

   task automatic push_expected(input int p, input logic [31:0] ba);
      int   eff;
      exp_t e;
      eff = (p == 0 || p > 16) ? 16 : p;
      for (int idx = 0; idx < eff; idx++) begin
         int plane;
         plane = eff - 1 - idx;
         e.addr = 15'((ba + 32'(idx)) & 32'h7FFF);
         for (int j = 0; j < NW; j++) e.word[j] = elem[j][plane];
         e.last = (idx == eff - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_block(input int p, input logic [31:0] ba, input int n_el,
                             input bit gaps, input bit noise);
      if (n_el == NW) push_expected(p, ba);
      @(negedge clk);
      prec = 32'(p); baddr = ba; start = 1'b1; iword = elem[0]; iword_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; prec = $urandom; baddr = $urandom;
      check("busy_in_collect", 64'(busy), 64'd1);
      for (int j = 1; j < n_el; j++) begin
         if (gaps && gap_at[j]) begin
            iword_valid = 1'b0; iword = $urandom;
            @(negedge clk);
         end
         iword_valid = 1'b1; iword = elem[j];
         @(negedge clk);
      end
      iword_valid = 1'b0;
      if (n_el == NW) begin
         check("first_write_latency", 64'(mvu_wr_en), 64'd1);
         if (noise) begin
            for (int k = 0; k < 3; k++) begin
               start = 1'b1; iword_valid = 1'b1; iword = $urandom;
               @(negedge clk);
            end
            start = 1'b0; iword_valid = 1'b0;
         end
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; prec = '0; baddr = '0; start = 1'b0; iword = '0; iword_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wr_en", 64'(mvu_wr_en), 64'd0);
      check("rst_wr_addr", 64'(mvu_wr_addr), 64'd0);
      check("rst_wr_word", mvu_wr_word, 64'd0);
      check("rst_ready", 64'(iword_ready), 64'd1);
      rst_n = 1'b1;

      // Idle valid without start must not begin a block
      @(negedge clk); iword_valid = 1'b1; iword = 32'h5;
      @(negedge clk); iword_valid = 1'b0;
      check("idle_valid_ignored", 64'(busy), 64'd0);

      for (int j = 0; j < NW; j++) elem[j] = 32'(j % 4);
      send_block(2, 32'h10, NW, 0, 0);
      drain("t1_drain");

      for (int j = 0; j < NW; j++) elem[j] = 32'h8001;
      send_block(16, 32'h100, NW, 0, 0);
      drain("t2_drain");

      for (int j = 0; j < NW; j++) elem[j] = 32'hFFFF_0000 | 32'($urandom_range(0, 16'hFFFF));
      send_block(0, 32'h200, NW, 0, 0);
      drain("t3a_drain");
      send_block(20, 32'h300, NW, 0, 0);
      drain("t3b_drain");

      for (int j = 0; j < NW; j++) elem[j] = $urandom;
      send_block(3, 32'h7FFF, NW, 0, 0);
      drain("t4_drain");

      for (int j = 0; j < NW; j++) begin
         elem[j]   = $urandom;
         gap_at[j] = 0;
      end
      for (int k = 0; k < 5; k++) gap_at[$urandom_range(1, NW - 1)] = 1;
      send_block(8, 32'h40, NW, 1, 1);
      drain("t5_drain");

      for (int j = 0; j < NW; j++) elem[j] = $urandom;
      send_block(8, 32'h20, 30, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_wr_en", 64'(mvu_wr_en), 64'd0);
      check("midrst_wr_addr", 64'(mvu_wr_addr), 64'd0);
      check("midrst_wr_word", mvu_wr_word, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int j = 0; j < NW; j++) elem[j] = $urandom;
      send_block(1, 32'h55, NW, 0, 0);
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
